leve_irf_wb: RTL and testbench
==============================

Name: leve_irf_wb

Overview:
- Writeback arbiter and producer side of the integer register file write port.
- Collects results from ALU (fixed latency, no backpressure), CSR unit (valid/ready) and load/store unit (valid/ready, variable latency, buffered in a small FIFO).
- Issues at most one registered write per cycle on RD_WE/RD/RD_D plus CSR_WE/CSR_D.
- Keeps a busy scoreboard of destination registers so decode can stall on RAW hazards.

Parameters:
XLEN, 64, data width; matches `XLEN.
NUM_REG, 32, architectural integer registers; index width is 5.
LSU_DEPTH, 4, load-result FIFO entries; power of two, >= 2.

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  synchronous active-high reset
ALU_VALID  in  1  ALU result valid this cycle; always accepted
ALU_RD  in  5  ALU destination
ALU_D  in  XLEN  ALU result
CSR_VALID  in  1  CSR read result valid
CSR_READY  out  1  CSR result accepted this cycle
CSR_RD  in  5  CSR destination
CSR_RDATA  in  XLEN  CSR old value to write to rd
LSU_VALID  in  1  load result valid
LSU_READY  out  1  load result accepted this cycle
LSU_RD  in  5  load destination
LSU_D  in  XLEN  load data, already sign/zero-extended
ISSUE_VALID  in  1  instruction with rd issued; mark ISSUE_RD busy
ISSUE_RD  in  5  destination being issued
RS1  in  5  decode source 1 query
RS2  in  5  decode source 2 query
RS1_BUSY  out  1  RS1 has a pending write
RS2_BUSY  out  1  RS2 has a pending write
RD_WE  out  1  register-file write enable (registered)
RD  out  5  write destination (registered)
RD_D  out  XLEN  write data for ALU/LSU results (registered)
CSR_WE  out  1  selects CSR_D as write data (registered)
CSR_D  out  XLEN  write data for CSR results (registered)

Behaviour:
- Reset state:
  - RD_WE=0, CSR_WE=0, RD=0, RD_D=0, CSR_D=0.
  - FIFO empty (count=0, pointers 0).
  - Scoreboard all clear.
  - Reset mid-operation discards FIFO contents and pending busy bits.
  - CSR_READY=0 and LSU_READY=0 while RST=1.
- Arbitration, fixed priority ALU > CSR > LSU FIFO head. Exactly one source wins per cycle; the winner is registered to the outputs next edge, so latency is 1 cycle.
- CSR_READY = !ALU_VALID. The CSR source is accepted when CSR_VALID && CSR_READY.
  - CSR win: CSR_WE=1, CSR_D=CSR_RDATA, RD_WE=1. RD_D holds its previous value.
- ALU win or FIFO-pop win: CSR_WE=0, RD_D=data, RD_WE=1.
- LSU path:
  - LSU_READY = (count != LSU_DEPTH), computed from registered count only. No same-cycle pass-through, even when a pop happens in the same cycle.
  - Accept pushes to the tail. The entry is eligible from the next cycle, so minimum LSU latency is 2 cycles.
  - Pop occurs when FIFO is non-empty and neither ALU nor accepted CSR is present.
  - Simultaneous push and pop leaves count unchanged. Pointers wrap modulo LSU_DEPTH.
- Idle cycle (no winner): RD_WE=0, CSR_WE=0. RD, RD_D and CSR_D hold.
- x0: a winning result with rd==0 is consumed (FIFO popped, CSR handshake completed) but produces RD_WE=0 and CSR_WE=0.
- Starvation: the LSU FIFO may starve under continuous ALU traffic. This is permitted by design; no fairness counter.
- Scoreboard: busy[1..31], busy[0] tied 0.
  - Set on ISSUE_VALID for ISSUE_RD.
  - Clear on the edge at which the write for that rd is registered, i.e. when the winner is selected.
  - Same-cycle set and clear of the same index: set wins.
  - RSx_BUSY = busy[RSx], combinational from the registered vector.
- Write-after-write to the same rd is not tracked. Issue logic guarantees at most one outstanding producer per rd.

Test Plan:
1. Reset: RST=1 for 2 cycles with LSU_VALID=1 -> RD_WE=0, CSR_WE=0, LSU_READY=0, RS1_BUSY=0 for RS1=5; after release LSU_READY=1.
2. ALU write: ISSUE_RD=7 at cycle0; ALU_VALID, ALU_RD=7, ALU_D=0x1234 at cycle2 -> RS1_BUSY(RS1=7)=1 during cycles 1-2; cycle3 RD_WE=1, RD=7, RD_D=0x1234, CSR_WE=0; RS1_BUSY=0 from cycle3.
3. CSR vs ALU collision: cycle0 ALU_VALID(rd=3,D=0xA), CSR_VALID(rd=4,RDATA=0xB) -> CSR_READY=0 cycle0; cycle1 RD=3/RD_D=0xA; CSR accepted cycle1; cycle2 RD=4, CSR_WE=1, CSR_D=0xB.
4. LSU FIFO fill: push 4 loads (rd=10..13, D=0x10..0x13) while ALU_VALID held for 6 cycles -> LSU_READY=0 after 4th push. After ALU drops, writes rd=10..13 in order on consecutive cycles with data 0x10..0x13.
5. x0 drop: LSU result rd=0, D=0xFFFF -> FIFO pops, RD_WE stays 0, LSU_READY returns 1.
6. Set/clear race: ISSUE_RD=9 in the same cycle an ALU write to rd=9 wins -> busy[9] remains 1 after the edge, RS2_BUSY(RS2=9)=1.

Source files
------------

// File: rtl/leve_irf_wb.sv
// Writeback arbiter for the integer register file: ALU > CSR > buffered LSU results,
// one registered write per cycle, plus a busy scoreboard for decode RAW stalls.
module leve_irf_wb #(
    parameter int XLEN      = 64,
    parameter int NUM_REG   = 32,
    parameter int LSU_DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            ALU_VALID,
    input  logic [4:0]      ALU_RD,
    input  logic [XLEN-1:0] ALU_D,
    input  logic            CSR_VALID,
    output logic            CSR_READY,
    input  logic [4:0]      CSR_RD,
    input  logic [XLEN-1:0] CSR_RDATA,
    input  logic            LSU_VALID,
    output logic            LSU_READY,
    input  logic [4:0]      LSU_RD,
    input  logic [XLEN-1:0] LSU_D,
    input  logic            ISSUE_VALID,
    input  logic [4:0]      ISSUE_RD,
    input  logic [4:0]      RS1,
    input  logic [4:0]      RS2,
    output logic            RS1_BUSY,
    output logic            RS2_BUSY,
    output logic            RD_WE,
    output logic [4:0]      RD,
    output logic [XLEN-1:0] RD_D,
    output logic            CSR_WE,
    output logic [XLEN-1:0] CSR_D
);

    localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(LSU_DEPTH);

    // Handshake: a transfer happens on a rising edge where VALID && READY;
    // READY never depends on the same-cycle VALID of the same source.

    logic [XLEN-1:0]    fifo_d  [LSU_DEPTH];
    logic [4:0]         fifo_rd [LSU_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [NUM_REG-1:0] busy;
    logic [NUM_REG-1:0] busy_nxt;

    logic            csr_win;
    logic            pop;
    logic            push;
    logic            any_win;
    logic [4:0]      win_rd;
    logic [XLEN-1:0] win_d;

    always_comb begin
        CSR_READY = !RST && !ALU_VALID;
        LSU_READY = !RST && (count != FULL_CNT);
        csr_win   = CSR_VALID && CSR_READY;
        pop       = (count != '0) && !ALU_VALID && !csr_win;
        push      = LSU_VALID && LSU_READY;
        any_win   = ALU_VALID || csr_win || pop;

        win_rd = fifo_rd[rd_ptr];
        win_d  = fifo_d[rd_ptr];
        if (ALU_VALID) begin
            win_rd = ALU_RD;
            win_d  = ALU_D;
        end else if (csr_win) begin
            win_rd = CSR_RD;
            win_d  = CSR_RDATA;
        end

        // A new issue to the same rd outranks the retiring write.
        busy_nxt = busy;
        if (any_win) busy_nxt[win_rd] = 1'b0;
        if (ISSUE_VALID) busy_nxt[ISSUE_RD] = 1'b1;
        busy_nxt[0] = 1'b0;

        RS1_BUSY = busy[RS1];
        RS2_BUSY = busy[RS2];
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_d[wr_ptr]  <= LSU_D;
            fifo_rd[wr_ptr] <= LSU_RD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
            RD_WE  <= 1'b0;
            CSR_WE <= 1'b0;
            RD     <= '0;
            RD_D   <= '0;
            CSR_D  <= '0;
        end else begin
            busy <= busy_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // x0 results are consumed but never written; outputs then hold like idle.
            if (any_win && (win_rd != 5'd0)) begin
                RD_WE <= 1'b1;
                RD    <= win_rd;
                if (csr_win) begin
                    CSR_WE <= 1'b1;
                    CSR_D  <= win_d;
                end else begin
                    CSR_WE <= 1'b0;
                    RD_D   <= win_d;
                end
            end else begin
                RD_WE  <= 1'b0;
                CSR_WE <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_leve_irf_wb.sv
// Directed bench for leve_irf_wb: vector table for ALU/CSR/scoreboard behaviour,
// hand sequences for LSU FIFO fill, x0 drop and mid-operation reset.
module tb_leve_irf_wb;

    logic        CLK;
    logic        RST;
    logic        ALU_VALID;
    logic [4:0]  ALU_RD;
    logic [63:0] ALU_D;
    logic        CSR_VALID;
    logic        CSR_READY;
    logic [4:0]  CSR_RD;
    logic [63:0] CSR_RDATA;
    logic        LSU_VALID;
    logic        LSU_READY;
    logic [4:0]  LSU_RD;
    logic [63:0] LSU_D;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic        RS1_BUSY;
    logic        RS2_BUSY;
    logic        RD_WE;
    logic [4:0]  RD;
    logic [63:0] RD_D;
    logic        CSR_WE;
    logic [63:0] CSR_D;

    int checks   = 0;
    int failures = 0;

    leve_irf_wb #(.XLEN(64), .NUM_REG(32), .LSU_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_D(ALU_D),
        .CSR_VALID(CSR_VALID), .CSR_READY(CSR_READY), .CSR_RD(CSR_RD), .CSR_RDATA(CSR_RDATA),
        .LSU_VALID(LSU_VALID), .LSU_READY(LSU_READY), .LSU_RD(LSU_RD), .LSU_D(LSU_D),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .RS1(RS1), .RS2(RS2), .RS1_BUSY(RS1_BUSY), .RS2_BUSY(RS2_BUSY),
        .RD_WE(RD_WE), .RD(RD), .RD_D(RD_D), .CSR_WE(CSR_WE), .CSR_D(CSR_D)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] alu_v, alu_rd, alu_d;
        logic [63:0] csr_v, csr_rd, csr_rdata;
        logic [63:0] iss_v, iss_rd, rs1, rs2;
        logic [63:0] e_csr_ready, e_lsu_ready, e_rs1_busy, e_rs2_busy;
        logic [63:0] e_rd_we, e_rd, e_rd_d, e_csr_we, e_csr_d;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ALU_VALID = 1'b0; ALU_RD = '0; ALU_D = '0;
        CSR_VALID = 1'b0; CSR_RD = '0; CSR_RDATA = '0;
        LSU_VALID = 1'b0; LSU_RD = '0; LSU_D = '0;
        ISSUE_VALID = 1'b0; ISSUE_RD = '0;
        RS1 = '0; RS2 = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_write(input string name, input logic we, input logic [4:0] rd,
                             input logic [63:0] d);
        chk({name, " RD_WE"}, 64'(RD_WE), 64'(we));
        chk({name, " CSR_WE"}, 64'(CSR_WE), 64'(0));
        chk({name, " RD"}, 64'(RD), 64'(rd));
        chk({name, " RD_D"}, RD_D, d);
    endtask

    initial begin
        // ALU write with busy tracking, CSR/ALU collision, same-cycle set/clear race
        tbl[0] = '{0,0,0,      0,0,0,    1,7, 7,0, 1,1,0,0, 0,0,0,0,0};
        tbl[1] = '{0,0,0,      0,0,0,    0,0, 7,0, 1,1,1,0, 0,0,0,0,0};
        tbl[2] = '{1,7,'h1234, 0,0,0,    0,0, 7,0, 0,1,1,0, 1,7,'h1234,0,0};
        tbl[3] = '{0,0,0,      0,0,0,    0,0, 7,0, 1,1,0,0, 0,7,'h1234,0,0};
        tbl[4] = '{1,3,'hA,    1,4,'hB,  0,0, 0,0, 0,1,0,0, 1,3,'hA,0,0};
        tbl[5] = '{0,0,0,      1,4,'hB,  0,0, 0,0, 1,1,0,0, 1,4,'hA,1,'hB};
        tbl[6] = '{1,9,'h99,   0,0,0,    1,9, 0,9, 0,1,0,0, 1,9,'h99,0,'hB};
        tbl[7] = '{0,0,0,      0,0,0,    0,0, 0,9, 1,1,0,1, 0,9,'h99,0,'hB};
        tbl[8] = '{1,9,'h5,    0,0,0,    0,0, 0,9, 0,1,0,1, 1,9,'h5,0,'hB};
        tbl[9] = '{0,0,0,      0,0,0,    0,0, 9,9, 1,1,0,0, 0,9,'h5,0,'hB};

        // Reset with a load offered: nothing may be accepted
        idle_inputs();
        RST = 1'b1;
        LSU_VALID = 1'b1; LSU_RD = 5'd6; LSU_D = 64'h66; RS1 = 5'd5;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset RD_WE", 64'(RD_WE), 64'(0));
            chk("reset CSR_WE", 64'(CSR_WE), 64'(0));
            chk("reset LSU_READY", 64'(LSU_READY), 64'(0));
            chk("reset CSR_READY", 64'(CSR_READY), 64'(0));
            chk("reset RS1_BUSY", 64'(RS1_BUSY), 64'(0));
        end
        chk("reset RD", 64'(RD), 64'(0));
        chk("reset RD_D", RD_D, 64'(0));
        chk("reset CSR_D", CSR_D, 64'(0));
        RST = 1'b0;
        idle_inputs();
        #1;
        chk("post-reset LSU_READY", 64'(LSU_READY), 64'(1));
        tick();
        chk("post-reset idle RD_WE", 64'(RD_WE), 64'(0));

        // Vector table
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            ALU_VALID = tbl[i].alu_v[0];  ALU_RD = tbl[i].alu_rd[4:0];  ALU_D = tbl[i].alu_d;
            CSR_VALID = tbl[i].csr_v[0];  CSR_RD = tbl[i].csr_rd[4:0];  CSR_RDATA = tbl[i].csr_rdata;
            ISSUE_VALID = tbl[i].iss_v[0]; ISSUE_RD = tbl[i].iss_rd[4:0];
            RS1 = tbl[i].rs1[4:0]; RS2 = tbl[i].rs2[4:0];
            #1;
            chk($sformatf("row%0d CSR_READY", i), 64'(CSR_READY), tbl[i].e_csr_ready);
            chk($sformatf("row%0d LSU_READY", i), 64'(LSU_READY), tbl[i].e_lsu_ready);
            chk($sformatf("row%0d RS1_BUSY", i), 64'(RS1_BUSY), tbl[i].e_rs1_busy);
            chk($sformatf("row%0d RS2_BUSY", i), 64'(RS2_BUSY), tbl[i].e_rs2_busy);
            tick();
            chk($sformatf("row%0d RD_WE", i), 64'(RD_WE), tbl[i].e_rd_we);
            chk($sformatf("row%0d RD", i), 64'(RD), tbl[i].e_rd);
            chk($sformatf("row%0d RD_D", i), RD_D, tbl[i].e_rd_d);
            chk($sformatf("row%0d CSR_WE", i), 64'(CSR_WE), tbl[i].e_csr_we);
            chk($sformatf("row%0d CSR_D", i), CSR_D, tbl[i].e_csr_d);
        end

        // LSU FIFO fill behind continuous ALU traffic
        for (int k = 0; k < 6; k++) begin
            idle_inputs();
            ALU_VALID = 1'b1; ALU_RD = 5'(20 + k); ALU_D = 64'(256 + k);
            if (k < 5) begin
                LSU_VALID = 1'b1; LSU_RD = 5'(10 + k); LSU_D = 64'(16 + k);
            end
            #1;
            chk($sformatf("fill%0d LSU_READY", k), 64'(LSU_READY), 64'(k < 4));
            tick();
            chk_write($sformatf("fill%0d", k), 1'b1, 5'(20 + k), 64'(256 + k));
        end
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            #1;
            chk($sformatf("drain%0d LSU_READY", k), 64'(LSU_READY), 64'(k != 0));
            tick();
            chk_write($sformatf("drain%0d", k), 1'b1, 5'(10 + k), 64'(16 + k));
        end
        idle_inputs();
        tick();
        chk("drained idle RD_WE", 64'(RD_WE), 64'(0));

        // x0 load is popped without a write; the load behind it still retires
        LSU_VALID = 1'b1; LSU_RD = 5'd0; LSU_D = 64'hFFFF;
        #1;
        chk("x0 push LSU_READY", 64'(LSU_READY), 64'(1));
        tick();
        chk("x0 push RD_WE", 64'(RD_WE), 64'(0));
        LSU_RD = 5'd15; LSU_D = 64'h77;
        #1;
        chk("x0 pop LSU_READY", 64'(LSU_READY), 64'(1));
        tick();
        chk("x0 pop RD_WE", 64'(RD_WE), 64'(0));
        chk("x0 pop CSR_WE", 64'(CSR_WE), 64'(0));
        idle_inputs();
        tick();
        chk_write("after x0", 1'b1, 5'd15, 64'h77);
        tick();
        chk("after x0 idle RD_WE", 64'(RD_WE), 64'(0));

        // x0 CSR result completes its handshake without a write
        CSR_VALID = 1'b1; CSR_RD = 5'd0; CSR_RDATA = 64'hDEAD;
        #1;
        chk("csr x0 CSR_READY", 64'(CSR_READY), 64'(1));
        tick();
        chk("csr x0 RD_WE", 64'(RD_WE), 64'(0));
        chk("csr x0 CSR_WE", 64'(CSR_WE), 64'(0));

        // Reset mid-operation discards queued loads and busy bits
        idle_inputs();
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'd12;
        ALU_VALID = 1'b1; ALU_RD = 5'd21; ALU_D = 64'h21;
        LSU_VALID = 1'b1; LSU_RD = 5'd11; LSU_D = 64'h55;
        tick();
        idle_inputs();
        ALU_VALID = 1'b1; ALU_RD = 5'd22; ALU_D = 64'h22;
        LSU_VALID = 1'b1; LSU_RD = 5'd13; LSU_D = 64'h66;
        RS1 = 5'd12;
        #1;
        chk("pre-rst RS1_BUSY", 64'(RS1_BUSY), 64'(1));
        tick();
        idle_inputs();
        RST = 1'b1; RS1 = 5'd12;
        #1;
        chk("mid-rst LSU_READY", 64'(LSU_READY), 64'(0));
        chk("mid-rst CSR_READY", 64'(CSR_READY), 64'(0));
        tick();
        chk("mid-rst RD_WE", 64'(RD_WE), 64'(0));
        RST = 1'b0;
        #1;
        chk("mid-rst RS1_BUSY", 64'(RS1_BUSY), 64'(0));
        chk("mid-rst LSU_READY after", 64'(LSU_READY), 64'(1));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("mid-rst drain%0d RD_WE", c), 64'(RD_WE), 64'(0));
        end

        // Report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
